// File: rtl/sinc_pkg.sv
// Shared types and the scale+saturate helper for the sinc3 output stage.
// Build option: SINC_ROUND_EN selects round-half-up scaling instead of truncation.
package sinc_pkg;

    localparam int SINC_IN_W  = 20;
    localparam int SINC_OUT_W = 16;

    typedef logic signed [SINC_IN_W-1:0]  sinc_raw_t;
    typedef logic signed [SINC_OUT_W-1:0] sinc_sample_t;

    // 33-bit working width covers any IN_W up to 32 plus the rounding carry.
    function automatic logic signed [31:0] sat_shift(
        input  logic signed [31:0] din,
        input  int                 shift,
        input  int                 out_w,
        output logic               clipped
    );
        logic signed [32:0] s;
        logic signed [32:0] max_v;
        logic signed [32:0] min_v;
        s = {din[31], din};
`ifdef SINC_ROUND_EN
        if (shift > 0) begin
            s = s + (33'sd1 <<< (shift - 1));
        end else begin
            s = s;
        end
`endif
        s     = s >>> shift;
        max_v = (33'sd1 <<< (out_w - 1)) - 33'sd1;
        min_v = -(33'sd1 <<< (out_w - 1));
        if (s > max_v) begin
            clipped = 1'b1;
            s       = max_v;
        end else if (s < min_v) begin
            clipped = 1'b1;
            s       = min_v;
        end else begin
            clipped = 1'b0;
        end
        return s[31:0];
    endfunction

endpackage

// File: rtl/sinc_out_fifo_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head and separate level count.
// push/pop arrive already qualified by the parent (no push when full unless popping).
module sinc_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [W-1:0]           data,
    input  logic                   push,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_nxt_s;
    logic [LW-1:0] level_r;
    logic [LW-1:0] level_nxt_s;
    logic [W-1:0]  head_r;
    logic [W-1:0]  head_nxt_s;
    logic          valid_r;

    // Next level and next head; when popping the last stored entry the new head can only be the incoming word.
    always_comb begin
        rd_nxt_s    = rd_ptr_r + AW'(1);
        level_nxt_s = level_r;
        head_nxt_s  = head_r;
        case ({push, pop})
            2'b10:   level_nxt_s = level_r + LW'(1);
            2'b01:   level_nxt_s = level_r - LW'(1);
            default: level_nxt_s = level_r;
        endcase
        if (pop) begin
            if (level_r > LW'(1)) begin
                head_nxt_s = mem_r[rd_nxt_s];
            end else if (push) begin
                head_nxt_s = data;
            end else begin
                head_nxt_s = head_r;
            end
        end else if (push && (level_r == LW'(0))) begin
            head_nxt_s = data;
        end else begin
            head_nxt_s = head_r;
        end
    end

    // Storage array; pointers gate its meaning so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= data;
        end
    end

    // Pointers, level, registered head and valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            level_r  <= '0;
            head_r   <= '0;
            valid_r  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_nxt_s;
            end
            level_r <= level_nxt_s;
            head_r  <= head_nxt_s;
            valid_r <= (level_nxt_s != LW'(0));
        end
    end

    assign head  = head_r;
    assign empty = ~valid_r;
    assign full  = (level_r == LW'(DEPTH));
    assign level = level_r;

endmodule

// File: rtl/sinc_out_fifo.sv
// sinc3 output stage: scale, saturate, buffer in an FWFT FIFO, sticky SAT/OVF flags.
// Build option: SINC_ROUND_EN enables round-half-up before the shift (see sinc_pkg).
module sinc_out_fifo
    import sinc_pkg::*;
#(
    parameter int IN_W  = SINC_IN_W,
    parameter int OUT_W = SINC_OUT_W,
    parameter int SHIFT = 0,
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [IN_W-1:0]        IN_DATA,
    input  logic                   IN_STB,
    output logic [OUT_W-1:0]       OUT_DATA,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [$clog2(DEPTH):0] LEVEL,
    output logic                   SAT,
    output logic                   OVF,
    input  logic                   CLR
);

    logic signed [31:0] scaled_s;
    logic [OUT_W-1:0]   sample_s;
    logic               clip_s;
    logic               full_s;
    logic               empty_s;
    logic               pop_s;
    logic               push_s;
    logic               drop_s;
    logic               sat_r;
    logic               ovf_r;

    // Scale and saturate the incoming sample.
    always_comb begin
        clip_s   = 1'b0;
        scaled_s = sat_shift(32'(signed'(IN_DATA)), SHIFT, OUT_W, clip_s);
        sample_s = OUT_W'(scaled_s);
    end

    // A same-edge pop frees the slot, so a full FIFO still accepts the push.
    assign pop_s  = ~empty_s & OUT_READY;
    assign push_s = IN_STB & (~full_s | pop_s);
    assign drop_s = IN_STB & full_s & ~pop_s;

    sinc_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST),
        .data  (sample_s),
        .push  (push_s),
        .pop   (pop_s),
        .head  (OUT_DATA),
        .full  (full_s),
        .empty (empty_s),
        .level (LEVEL)
    );

    // Sticky flags: CLR clears, but a new event on the same edge wins.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sat_r <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            sat_r <= (sat_r & ~CLR) | (IN_STB & clip_s);
            ovf_r <= (ovf_r & ~CLR) | drop_s;
        end
    end

    assign OUT_VALID = ~empty_s;
    assign SAT       = sat_r;
    assign OVF       = ovf_r;

endmodule
